dvp_16_8bit_tx: RTL

DVP_16_8BIT_TX -- requirements
Module: dvp_16_8bit_tx

---
 rtl/dvp_16_8bit_tx_pkg.sv | 30 +++
 rtl/dvp_16_8bit_tx_pix_fifo.sv | 53 +++++
 rtl/dvp_16_8bit_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dvp_16_8bit_tx_pkg.sv
// Shared types and default timing for the DVP 16-to-8 bit transmitter.
// Defaults describe a 640x480 frame.
package dvp_16_8bit_tx_pkg;

    localparam int unsigned DefHPixels  = 640;
    localparam int unsigned DefVLines   = 480;
    localparam int unsigned DefHBlank   = 64;
    localparam int unsigned DefVsCycles = 8;
    localparam int unsigned DefVBack    = 32;

    localparam int unsigned PixWidth     = 16;
    localparam int unsigned PixFifoDepth = 4;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StLwait,
        StLine,
        StHblank
    } dvp_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dvp_16_8bit_tx_pix_fifo.sv
// Small synchronous pixel FIFO with show-ahead read data.
// Depth must be a power of two; a push on a full FIFO is taken only alongside a pop.
module dvp_16_8bit_tx_pix_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q;
    logic [AddrW:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/dvp_16_8bit_tx.sv
// DVP transmitter: drains RGB565 pixels from a small FIFO and emits them as an 8-bit
// byte stream (upper byte first) framed by vsync/href.
module dvp_16_8bit_tx
    import dvp_16_8bit_tx_pkg::*;
#(
    parameter int unsigned H_PIXELS  = DefHPixels,
    parameter int unsigned V_LINES   = DefVLines,
    parameter int unsigned H_BLANK   = DefHBlank,
    parameter int unsigned VS_CYCLES = DefVsCycles,
    parameter int unsigned V_BACK    = DefVBack
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  pdata_o,
    output logic        frame_done,
    output logic        underflow,
    output logic        busy
);

    localparam int unsigned LineW = $clog2(V_LINES + 1);
    localparam int unsigned ByteW = $clog2(2 * H_PIXELS + 1);
    localparam int unsigned TmrW  = $clog2(max3(VS_CYCLES, V_BACK, H_BLANK) + 1);

    localparam logic [ByteW-1:0] ByteLast  = ByteW'(2 * H_PIXELS - 1);
    localparam logic [LineW-1:0] LineTotal = LineW'(V_LINES);
    localparam logic [TmrW-1:0]  VsLast    = TmrW'(VS_CYCLES - 1);
    localparam logic [TmrW-1:0]  VbLast    = TmrW'(V_BACK - 1);
    localparam logic [TmrW-1:0]  HbLast    = TmrW'(H_BLANK - 1);

    dvp_state_e       state_q;
    logic [TmrW-1:0]  tmr_q;
    logic [LineW-1:0] line_cnt_q;
    logic [LineW-1:0] line_nxt;
    logic [ByteW-1:0] byte_cnt_q;
    logic [7:0]       hold_q;
    logic [7:0]       pdata_q;
    logic             vsync_q;
    logic             href_q;
    logic             frame_done_q;
    logic             underflow_q;
    logic             rdy_en_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [15:0]      fifo_rdata;

    // Held low through reset and for the first clock after it.
    assign s_ready   = rdy_en_q && !fifo_full;
    assign fifo_push = s_valid && s_ready;

    // Pop on the edge that opens a phase-0 byte cycle.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == StLwait) ||
                       ((state_q == StLine) && byte_cnt_q[0] && (byte_cnt_q != ByteLast)));

    assign line_nxt = line_cnt_q + 1'b1;

    dvp_16_8bit_tx_pix_fifo #(
        .Width (PixWidth),
        .Depth (PixFifoDepth)
    ) pix_fifo (
        .clk_i   (pclk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .wdata_i (s_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            line_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            hold_q       <= 8'h00;
            pdata_q      <= 8'h00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            rdy_en_q     <= 1'b1;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q     <= StVsync;
                        vsync_q     <= 1'b1;
                        tmr_q       <= '0;
                        line_cnt_q  <= '0;
                        byte_cnt_q  <= '0;
                        underflow_q <= 1'b0;
                    end
                end
                StVsync: begin
                    if (tmr_q == VsLast) begin
                        vsync_q <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= (V_BACK == 0) ? StLwait : StVback;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StVback: begin
                    if (tmr_q == VbLast) begin
                        tmr_q   <= '0;
                        state_q <= StLwait;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StLwait: begin
                    if (!fifo_empty) begin
                        state_q    <= StLine;
                        href_q     <= 1'b1;
                        byte_cnt_q <= '0;
                        pdata_q    <= fifo_rdata[15:8];
                        hold_q     <= fifo_rdata[7:0];
                    end
                end
                StLine: begin
                    if (byte_cnt_q == ByteLast) begin
                        href_q     <= 1'b0;
                        pdata_q    <= 8'h00;
                        line_cnt_q <= line_nxt;
                        tmr_q      <= '0;
                        if (line_nxt == LineTotal) begin
                            state_q      <= StIdle;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= (H_BLANK == 0) ? StLwait : StHblank;
                        end
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q[0]) begin
                            // Missing pixel: keep the line length, send zeros for both bytes.
                            if (fifo_empty) begin
                                pdata_q     <= 8'h00;
                                hold_q      <= 8'h00;
                                underflow_q <= 1'b1;
                            end else begin
                                pdata_q <= fifo_rdata[15:8];
                                hold_q  <= fifo_rdata[7:0];
                            end
                        end else begin
                            pdata_q <= hold_q;
                        end
                    end
                end
                StHblank: begin
                    if (tmr_q == HbLast) begin
                        tmr_q   <= '0;
                        state_q <= StLwait;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign pdata_o    = pdata_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;
    assign busy       = (state_q != StIdle);

endmodule
